// File: rtl/pipeline_trace_buffer_if.sv
// Trace buffer bus: channel sample inputs and the valid/ready readout port.
// The trace block takes the slave side; the sampling pipeline and the drain consumer
// take the master side.
interface pipeline_trace_buffer_if #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CH_WIDTH    = 32,
  parameter int unsigned CYCLE_WIDTH = 16
);
  logic [CHANNELS*CH_WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0]          ch_valid;
  logic                         rd_ready;
  logic                         rd_valid;
  logic [CHANNELS*CH_WIDTH-1:0] rd_data;
  logic [CHANNELS-1:0]          rd_chv;
  logic [CYCLE_WIDTH-1:0]       rd_cycle;

  modport master (
    output ch_data, ch_valid, rd_ready,
    input  rd_valid, rd_data, rd_chv, rd_cycle
  );

  modport slave (
    input  ch_data, ch_valid, rd_ready,
    output rd_valid, rd_data, rd_chv, rd_cycle
  );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Pipeline trace buffer: snapshots CHANNELS pipeline-register words per cycle into a
// circular buffer tagged with a free-running cycle number, stops on request or at a
// programmed cycle, then drains oldest-first over valid/ready.
// Optional macro TRACE_CHANGE_ONLY_EN: only write samples that differ from the last
// written snapshot (change-only logging).
module pipeline_trace_buffer #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CH_WIDTH    = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CYCLE_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  pipeline_trace_buffer_if.slave  trace_if,
  input  logic                    arm_i,
  input  logic                    stop_req_i,
  input  logic [CYCLE_WIDTH-1:0]  stop_cycle_i,
  output logic [CYCLE_WIDTH-1:0]  cycle_count_o,
  output logic [1:0]              state_o,
  output logic                    overflow_o,
  output logic                    done_o
);

  localparam int unsigned DataW  = CHANNELS * CH_WIDTH;
  localparam int unsigned SampW  = CHANNELS + DataW;
  localparam int unsigned EntryW = CYCLE_WIDTH + SampW;
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StCapture = 2'b01,
    StReadout = 2'b10,
    StDone    = 2'b11
  } state_e;

  state_e                 state_q;
  logic [CYCLE_WIDTH-1:0] cycle_q;
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q;
  logic                   overflow_q, done_q;
  logic [EntryW-1:0]      mem_q [DEPTH];

  logic              full, hit_stop, wr_en, rd_valid, xfer, arm_ok;
  logic [SampW-1:0]  sample;
  logic [CntW-1:0]   cnt_after_wr;
  logic [EntryW-1:0] rd_entry;

`ifdef TRACE_CHANGE_ONLY_EN
  logic [SampW-1:0] shadow_q;
  logic             shadow_vld_q;
`endif

  // Capture/readout decode and combinational read port
  always_comb begin
    arm_ok   = ((state_q == StIdle) || (state_q == StDone)) && arm_i;
    full     = (count_q == CntW'(DEPTH));
    hit_stop = stop_req_i || ((stop_cycle_i != '0) && (cycle_q == stop_cycle_i));
    sample   = {trace_if.ch_valid, trace_if.ch_data};
    wr_en    = (state_q == StCapture) && (|trace_if.ch_valid);
`ifdef TRACE_CHANGE_ONLY_EN
    // First valid sample after arm always lands; later ones only when something changed
    wr_en    = wr_en && (!shadow_vld_q || (sample != shadow_q));
`endif
    cnt_after_wr = (wr_en && !full) ? count_q + CntW'(1) : count_q;
    rd_valid = (state_q == StReadout) && (count_q != '0);
    xfer     = rd_valid && trace_if.rd_ready;
    rd_entry = mem_q[rd_ptr_q];
    // Gate with rd_valid so the un-reset RAM never leaks onto the port
    trace_if.rd_valid = rd_valid;
    trace_if.rd_data  = rd_valid ? rd_entry[DataW-1:0] : '0;
    trace_if.rd_chv   = rd_valid ? rd_entry[DataW +: CHANNELS] : '0;
    trace_if.rd_cycle = rd_valid ? rd_entry[SampW +: CYCLE_WIDTH] : '0;
  end

  // Buffer RAM write; contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_en) begin
      mem_q[wr_ptr_q] <= {cycle_q, sample};
    end
  end

`ifdef TRACE_CHANGE_ONLY_EN
  // Shadow of the last written snapshot for change detection
  always_ff @(posedge clk_i) begin
    if (reset_i || arm_ok) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
    end else if (wr_en) begin
      shadow_q     <= sample;
      shadow_vld_q <= 1'b1;
    end
  end
`endif

  // Control FSM with pointers, occupancy, cycle counter and registered status
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      cycle_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cycle_q <= cycle_q + CYCLE_WIDTH'(1);
      case (state_q)
        StIdle, StDone: begin
          if (arm_ok) begin
            state_q    <= StCapture;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
          end
        end
        StCapture: begin
          if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
            // Full: the new entry overwrites the oldest, so the read side moves too
            if (full) begin
              rd_ptr_q   <= rd_ptr_q + PtrW'(1);
              overflow_q <= 1'b1;
            end
          end
          count_q <= cnt_after_wr;
          if (hit_stop) begin
            if (cnt_after_wr != '0) begin
              state_q <= StReadout;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StReadout: begin
          if (xfer) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q  <= count_q - CntW'(1);
            if (count_q == CntW'(1)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cycle_count_o = cycle_q;
  assign state_o       = state_q;
  assign overflow_o    = overflow_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer: capture, overflow, auto-stop, backpressure,
// mid-readout reset, empty capture and change-only logging.
module tb_pipeline_trace_buffer;

  localparam int unsigned CH  = 4;
  localparam int unsigned CW  = 32;
  localparam int unsigned D   = 16;
  localparam int unsigned CYW = 16;

  logic           clk = 1'b0;
  logic           reset, arm, stop_req;
  logic [CYW-1:0] stop_cycle;
  logic [CYW-1:0] cycle_count;
  logic [1:0]     state;
  logic           overflow, done;

  int             n_chk = 0;
  int             n_bad = 0;
  logic [CYW-1:0] cyc;
  logic [CYW-1:0] tags [0:31];
  int             n_ent;
  int             exp_ent;

  always #5 clk = ~clk;

  pipeline_trace_buffer_if #(.CHANNELS(CH), .CH_WIDTH(CW), .CYCLE_WIDTH(CYW)) tr_if ();

  pipeline_trace_buffer #(
    .CHANNELS   (CH),
    .CH_WIDTH   (CW),
    .DEPTH      (D),
    .CYCLE_WIDTH(CYW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .trace_if     (tr_if),
    .arm_i        (arm),
    .stop_req_i   (stop_req),
    .stop_cycle_i (stop_cycle),
    .cycle_count_o(cycle_count),
    .state_o      (state),
    .overflow_o   (overflow),
    .done_o       (done)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, keep the reference cycle count, settle 1 time unit past the edge
  task automatic tick();
    @(posedge clk);
    if (reset) cyc = '0;
    else cyc = cyc + 16'd1;
    #1;
  endtask

  function automatic logic [127:0] mk_data(input int k);
    logic [127:0] d;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = 32'(k * 16 + i);
    return d;
  endfunction

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; arm = 1'b0; stop_req = 1'b0; stop_cycle = '0; cyc = '0;
    tr_if.ch_valid = '0; tr_if.ch_data = '0; tr_if.rd_ready = 1'b0;

    // 1: reset state, then 3 samples with stop on the third
    tick(); tick();
    check_eq("rst_state", 128'(state), 128'(2'b00));
    check_eq("rst_cycle", 128'(cycle_count), 128'(0));
    check_eq("rst_rd_valid", 128'(tr_if.rd_valid), 128'(0));
    check_eq("rst_done", 128'(done), 128'(0));
    check_eq("rst_overflow", 128'(overflow), 128'(0));
    check_eq("rst_rd_data", tr_if.rd_data, 128'(0));
    check_eq("rst_rd_cycle", 128'(tr_if.rd_cycle), 128'(0));
    reset = 1'b0;
    tick();
    check_eq("cycle_inc", 128'(cycle_count), 128'(cyc));
    do_arm();
    check_eq("t1_capture", 128'(state), 128'(2'b01));
    for (int k = 1; k <= 3; k++) begin
      tr_if.ch_valid = 4'hF;
      tr_if.ch_data  = mk_data(k);
      tags[k]        = cyc;
      stop_req       = (k == 3);
      tick();
    end
    tr_if.ch_valid = '0; stop_req = 1'b0;
    check_eq("t1_readout", 128'(state), 128'(2'b10));
    check_eq("t1_overflow", 128'(overflow), 128'(0));
    tr_if.rd_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      check_eq("t1_rd_valid", 128'(tr_if.rd_valid), 128'(1));
      check_eq("t1_rd_cycle", 128'(tr_if.rd_cycle), 128'(tags[k]));
      check_eq("t1_rd_data", tr_if.rd_data, mk_data(k));
      check_eq("t1_rd_chv", 128'(tr_if.rd_chv), 128'(4'hF));
      if (k < 3) check_eq("t1_not_done", 128'(done), 128'(0));
      tick();
    end
    tr_if.rd_ready = 1'b0;
    check_eq("t1_done_state", 128'(state), 128'(2'b11));
    check_eq("t1_done", 128'(done), 128'(1));
    check_eq("t1_rd_valid_off", 128'(tr_if.rd_valid), 128'(0));

    // 2: 20 samples into 16 entries, then backpressure and full drain
    do_arm();
    check_eq("t2_rearm", 128'(state), 128'(2'b01));
    check_eq("t2_done_clr", 128'(done), 128'(0));
    for (int k = 1; k <= 20; k++) begin
      tr_if.ch_valid = 4'h5;
      tr_if.ch_data  = mk_data(100 + k);
      tags[k]        = cyc;
      stop_req       = (k == 20);
      tick();
    end
    tr_if.ch_valid = '0; stop_req = 1'b0;
    check_eq("t2_readout", 128'(state), 128'(2'b10));
    check_eq("t2_overflow", 128'(overflow), 128'(1));
    // 4: stall with rd_ready low; outputs must hold
    for (int j = 0; j < 4; j++) begin
      check_eq("t4_hold_valid", 128'(tr_if.rd_valid), 128'(1));
      check_eq("t4_hold_cycle", 128'(tr_if.rd_cycle), 128'(tags[5]));
      check_eq("t4_hold_data", tr_if.rd_data, mk_data(105));
      tick();
    end
    tr_if.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("t2_rd_cycle", 128'(tr_if.rd_cycle), 128'(tags[5 + i]));
      check_eq("t2_rd_data", tr_if.rd_data, mk_data(105 + i));
      check_eq("t2_rd_chv", 128'(tr_if.rd_chv), 128'(4'h5));
      tick();
    end
    tr_if.rd_ready = 1'b0;
    check_eq("t2_done", 128'(done), 128'(1));
    check_eq("t2_empty", 128'(tr_if.rd_valid), 128'(0));

    // 3: auto-stop at cycle 5
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stop_cycle = 16'd5;
    do_arm();
    tr_if.ch_valid = 4'h1;
    for (int k = 1; k <= 5; k++) begin
      tr_if.ch_data = mk_data(200 + k);
      tick();
      if (k == 4) check_eq("t3_still_capture", 128'(state), 128'(2'b01));
    end
    tr_if.ch_valid = '0;
    stop_cycle = '0;
    check_eq("t3_readout", 128'(state), 128'(2'b10));
    tr_if.rd_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      check_eq("t3_rd_cycle", 128'(tr_if.rd_cycle), 128'(k));
      check_eq("t3_rd_data", tr_if.rd_data, mk_data(200 + k));
      tick();
    end
    tr_if.rd_ready = 1'b0;
    check_eq("t3_done", 128'(done), 128'(1));

    // 5: reset mid-readout with 6 entries pending
    do_arm();
    for (int k = 1; k <= 6; k++) begin
      tr_if.ch_valid = 4'h3;
      tr_if.ch_data  = mk_data(400 + k);
      stop_req       = (k == 6);
      tick();
    end
    tr_if.ch_valid = '0; stop_req = 1'b0;
    check_eq("t5_readout", 128'(state), 128'(2'b10));
    tick();
    reset = 1'b1;
    tr_if.rd_ready = 1'b1;
    tick();
    reset = 1'b0;
    tr_if.rd_ready = 1'b0;
    check_eq("t5_state", 128'(state), 128'(2'b00));
    check_eq("t5_rd_valid", 128'(tr_if.rd_valid), 128'(0));
    check_eq("t5_cycle", 128'(cycle_count), 128'(0));
    check_eq("t5_done", 128'(done), 128'(0));
    check_eq("t5_rd_data", tr_if.rd_data, 128'(0));

    // 6a: no valid samples -> straight to DONE
    do_arm();
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("t6_capture", 128'(state), 128'(2'b01));
      check_eq("t6_no_valid", 128'(tr_if.rd_valid), 128'(0));
    end
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    check_eq("t6_done_state", 128'(state), 128'(2'b11));
    check_eq("t6_done", 128'(done), 128'(1));
    check_eq("t6_rd_valid", 128'(tr_if.rd_valid), 128'(0));
    tick();
    check_eq("t6_rd_valid2", 128'(tr_if.rd_valid), 128'(0));

    // 6b: identical samples for 10 cycles
    do_arm();
    for (int k = 1; k <= 10; k++) begin
      tr_if.ch_valid = 4'hF;
      tr_if.ch_data  = mk_data(300);
      stop_req       = (k == 10);
      tick();
    end
    tr_if.ch_valid = '0; stop_req = 1'b0;
    check_eq("t6b_readout", 128'(state), 128'(2'b10));
`ifdef TRACE_CHANGE_ONLY_EN
    exp_ent = 1;
`else
    exp_ent = 10;
`endif
    n_ent = 0;
    tr_if.rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tr_if.rd_valid) begin
        n_ent++;
        tick();
      end
    end
    tr_if.rd_ready = 1'b0;
    check_eq("t6b_entries", 128'(n_ent), 128'(exp_ent));
    check_eq("t6b_done", 128'(done), 128'(1));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
